// File: rtl/block_expander.sv
// Shared trace widths, plus the block expander: turns one compressed retirement
// block record back into its per-instruction uop stream.
package mure_pkg;
  localparam int XLEN        = 64;
  localparam int IRETIRE_LEN = 14;
  localparam int ITYPE_LEN   = 4;
  localparam int CAUSE_LEN   = 6;
  localparam int PRIV_LEN    = 2;
endpackage

module block_expander
  import mure_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [XLEN-1:0]        blk_iaddr_i,
  input  logic [IRETIRE_LEN-1:0] blk_iretire_i,
  input  logic                   blk_ilastsize_i,
  input  logic [ITYPE_LEN-1:0]   blk_itype_i,
  input  logic [CAUSE_LEN-1:0]   blk_cause_i,
  input  logic [XLEN-1:0]        blk_tval_i,
  input  logic [PRIV_LEN-1:0]    blk_priv_i,
  output logic                   fetch_req_o,
  output logic [XLEN-1:0]        fetch_addr_o,
  input  logic                   fetch_rvalid_i,
  input  logic [1:0]             fetch_rdata_i,
  output logic                   uop_valid_o,
  input  logic                   uop_ready_i,
  output logic [XLEN-1:0]        uop_pc_o,
  output logic                   uop_compressed_o,
  output logic                   uop_last_o,
  output logic [ITYPE_LEN-1:0]   uop_itype_o,
  output logic [CAUSE_LEN-1:0]   uop_cause_o,
  output logic [XLEN-1:0]        uop_tval_o,
  output logic [PRIV_LEN-1:0]    uop_priv_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {S_IDLE, S_DECIDE, S_FETCH, S_WAIT, S_EMIT} state_e;

  state_e                 state_q;
  logic [XLEN-1:0]        pc_q;
  logic [IRETIRE_LEN-1:0] rem_q;
  logic                   ilast_q;
  logic [ITYPE_LEN-1:0]   itype_q;
  logic [CAUSE_LEN-1:0]   cause_q;
  logic [XLEN-1:0]        tval_q;
  logic [PRIV_LEN-1:0]    priv_q;
  logic                   error_q;

  logic [XLEN-1:0]        uop_pc_q;
  logic                   uop_c_q;
  logic                   uop_last_q;
  logic [ITYPE_LEN-1:0]   uop_itype_q;
  logic [CAUSE_LEN-1:0]   uop_cause_q;
  logic [XLEN-1:0]        uop_tval_q;
  logic [PRIV_LEN-1:0]    uop_priv_q;

  logic [IRETIRE_LEN-1:0] lastsz;
  logic                   rsp_c;
  logic [IRETIRE_LEN-1:0] rsp_sz;
  logic [IRETIRE_LEN-1:0] rem_d;
  logic [XLEN-1:0]        pc_d;

  // Size decode of the fetched instruction: only 2'b11 marks a 32-bit encoding.
  always_comb begin
    lastsz = ilast_q ? IRETIRE_LEN'(2) : IRETIRE_LEN'(1);
    rsp_c  = (fetch_rdata_i != 2'b11);
    rsp_sz = rsp_c ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    rem_d  = rem_q - rsp_sz;
    pc_d   = pc_q + (rsp_c ? XLEN'(2) : XLEN'(4));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      rem_q       <= '0;
      ilast_q     <= 1'b0;
      itype_q     <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      priv_q      <= '0;
      error_q     <= 1'b0;
      uop_pc_q    <= '0;
      uop_c_q     <= 1'b0;
      uop_last_q  <= 1'b0;
      uop_itype_q <= '0;
      uop_cause_q <= '0;
      uop_tval_q  <= '0;
      uop_priv_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (blk_valid_i) begin
            if (blk_iretire_i == '0) begin
              error_q <= 1'b1;
            end else begin
              pc_q    <= blk_iaddr_i;
              rem_q   <= blk_iretire_i;
              ilast_q <= blk_ilastsize_i;
              itype_q <= blk_itype_i;
              cause_q <= blk_cause_i;
              tval_q  <= blk_tval_i;
              priv_q  <= blk_priv_i;
              state_q <= S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          if (rem_q == lastsz) begin
            uop_pc_q    <= pc_q;
            uop_c_q     <= !ilast_q;
            uop_last_q  <= 1'b1;
            uop_itype_q <= itype_q;
            uop_cause_q <= cause_q;
            uop_tval_q  <= tval_q;
            uop_priv_q  <= priv_q;
            state_q     <= S_EMIT;
          end else if (rem_q < lastsz) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (fetch_rvalid_i) begin
            // Not enough halfwords left for the final instruction: the record is inconsistent.
            if (rem_d < lastsz) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              uop_pc_q    <= pc_q;
              uop_c_q     <= rsp_c;
              uop_last_q  <= 1'b0;
              uop_itype_q <= '0;
              uop_cause_q <= '0;
              uop_tval_q  <= '0;
              uop_priv_q  <= '0;
              pc_q        <= pc_d;
              rem_q       <= rem_d;
              state_q     <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (uop_ready_i) state_q <= uop_last_q ? S_IDLE : S_DECIDE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign blk_ready_o      = (state_q == S_IDLE);
  assign fetch_req_o      = (state_q == S_FETCH);
  assign fetch_addr_o     = (state_q == S_FETCH) ? pc_q : '0;
  assign uop_valid_o      = (state_q == S_EMIT);
  assign uop_pc_o         = uop_pc_q;
  assign uop_compressed_o = uop_c_q;
  assign uop_last_o       = uop_last_q;
  assign uop_itype_o      = uop_itype_q;
  assign uop_cause_o      = uop_cause_q;
  assign uop_tval_o       = uop_tval_q;
  assign uop_priv_o       = uop_priv_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_block_expander.sv
// Directed bench for block_expander: a table of block records with their expected
// uop streams, plus hand-written reset sequences.
module tb_block_expander;
  import mure_pkg::*;

  logic                   clk;
  logic                   rst_ni;
  logic                   blk_valid_i;
  logic                   blk_ready_o;
  logic [XLEN-1:0]        blk_iaddr_i;
  logic [IRETIRE_LEN-1:0] blk_iretire_i;
  logic                   blk_ilastsize_i;
  logic [ITYPE_LEN-1:0]   blk_itype_i;
  logic [CAUSE_LEN-1:0]   blk_cause_i;
  logic [XLEN-1:0]        blk_tval_i;
  logic [PRIV_LEN-1:0]    blk_priv_i;
  logic                   fetch_req_o;
  logic [XLEN-1:0]        fetch_addr_o;
  logic                   fetch_rvalid_i;
  logic [1:0]             fetch_rdata_i;
  logic                   uop_valid_o;
  logic                   uop_ready_i;
  logic [XLEN-1:0]        uop_pc_o;
  logic                   uop_compressed_o;
  logic                   uop_last_o;
  logic [ITYPE_LEN-1:0]   uop_itype_o;
  logic [CAUSE_LEN-1:0]   uop_cause_o;
  logic [XLEN-1:0]        uop_tval_o;
  logic [PRIV_LEN-1:0]    uop_priv_o;
  logic                   error_o;

  block_expander dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_iaddr_i(blk_iaddr_i), .blk_iretire_i(blk_iretire_i),
    .blk_ilastsize_i(blk_ilastsize_i), .blk_itype_i(blk_itype_i),
    .blk_cause_i(blk_cause_i), .blk_tval_i(blk_tval_i), .blk_priv_i(blk_priv_i),
    .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o),
    .fetch_rvalid_i(fetch_rvalid_i), .fetch_rdata_i(fetch_rdata_i),
    .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i),
    .uop_pc_o(uop_pc_o), .uop_compressed_o(uop_compressed_o), .uop_last_o(uop_last_o),
    .uop_itype_o(uop_itype_o), .uop_cause_o(uop_cause_o),
    .uop_tval_o(uop_tval_o), .uop_priv_o(uop_priv_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic                 c;
    logic                 last;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } uop_t;

  typedef struct {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilast;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    int                     nrsp;
    logic [1:0]             rsp0;
    logic [1:0]             rsp1;
    int                     lat;
    int                     stall;
    int                     nuop;
    int                     ubase;
    int                     nfetch;
    logic [XLEN-1:0]        faddr0;
    logic [XLEN-1:0]        faddr1;
    logic                   err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] rsp_q[$];
  int         rsp_lat = 1;

  vec_t vt[9];
  uop_t eu[7];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [XLEN-1:0] iaddr, input int iretire, input logic ilast,
                               input int itype, input int cause, input logic [XLEN-1:0] tval,
                               input int priv, input int nrsp, input logic [1:0] rsp0,
                               input logic [1:0] rsp1, input int lat, input int stall,
                               input int nuop, input int ubase, input int nfetch,
                               input logic [XLEN-1:0] fa0, input logic [XLEN-1:0] fa1,
                               input logic err);
    vec_t v;
    v.iaddr = iaddr; v.iretire = IRETIRE_LEN'(iretire); v.ilast = ilast;
    v.itype = ITYPE_LEN'(itype); v.cause = CAUSE_LEN'(cause); v.tval = tval;
    v.priv = PRIV_LEN'(priv); v.nrsp = nrsp; v.rsp0 = rsp0; v.rsp1 = rsp1;
    v.lat = lat; v.stall = stall; v.nuop = nuop; v.ubase = ubase; v.nfetch = nfetch;
    v.faddr0 = fa0; v.faddr1 = fa1; v.err = err;
    return v;
  endfunction

  function automatic uop_t mku(input logic [XLEN-1:0] pc, input logic c, input logic last,
                               input int itype, input int cause, input logic [XLEN-1:0] tval,
                               input int priv);
    uop_t u;
    u.pc = pc; u.c = c; u.last = last; u.itype = ITYPE_LEN'(itype);
    u.cause = CAUSE_LEN'(cause); u.tval = tval; u.priv = PRIV_LEN'(priv);
    return u;
  endfunction

  function automatic uop_t cur_uop();
    uop_t u;
    u.pc = uop_pc_o; u.c = uop_compressed_o; u.last = uop_last_o; u.itype = uop_itype_o;
    u.cause = uop_cause_o; u.tval = uop_tval_o; u.priv = uop_priv_o;
    return u;
  endfunction

  // Fetch responder: answers each request with the next queued data after rsp_lat cycles.
  initial begin
    fetch_rvalid_i = 1'b0;
    fetch_rdata_i  = 2'b00;
    forever begin
      @(negedge clk);
      if (fetch_req_o && rsp_q.size() > 0) begin
        logic [1:0] d;
        d = rsp_q.pop_front();
        repeat (rsp_lat) @(negedge clk);
        fetch_rdata_i  = d;
        fetch_rvalid_i = 1'b1;
        @(negedge clk);
        fetch_rvalid_i = 1'b0;
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int   n, nf, first_k, st, both;
    bit   have_snap, stable_ok;
    uop_t snap, cur;
    logic [XLEN-1:0] fa[2];
    n = 0; nf = 0; first_k = -1; st = 0; both = 0;
    have_snap = 1'b0; stable_ok = 1'b1; snap = '0;
    fa[0] = '0; fa[1] = '0;
    rsp_q.delete();
    if (v.nrsp > 0) rsp_q.push_back(v.rsp0);
    if (v.nrsp > 1) rsp_q.push_back(v.rsp1);
    rsp_lat = v.lat;

    @(negedge clk);
    check($sformatf("v%0d_ready_before", idx), 256'(blk_ready_o), 256'(1));
    blk_valid_i = 1'b1; blk_iaddr_i = v.iaddr; blk_iretire_i = v.iretire;
    blk_ilastsize_i = v.ilast; blk_itype_i = v.itype; blk_cause_i = v.cause;
    blk_tval_i = v.tval; blk_priv_i = v.priv;
    @(negedge clk);
    blk_valid_i = 1'b0;

    for (int k = 1; k <= 60; k++) begin
      if (fetch_req_o) begin
        if (nf < 2) fa[nf] = fetch_addr_o;
        nf++;
      end
      if (fetch_req_o && uop_valid_o) both++;
      if (uop_valid_o) begin
        cur = cur_uop();
        if (first_k < 0) first_k = k;
        if (!have_snap) begin
          snap = cur; have_snap = 1'b1; st = 0;
        end else if (cur !== snap) begin
          stable_ok = 1'b0;
        end
        if (st >= v.stall) begin
          uop_ready_i = 1'b1;
          if (n < v.nuop)
            check($sformatf("v%0d_uop%0d", idx, n), 256'(cur), 256'(eu[v.ubase + n]));
          n++;
          have_snap = 1'b0;
        end else begin
          uop_ready_i = 1'b0;
          st++;
        end
      end else begin
        uop_ready_i = 1'b0;
      end
      @(negedge clk);
    end
    uop_ready_i = 1'b0;

    check($sformatf("v%0d_nuop", idx), 256'(n), 256'(v.nuop));
    check($sformatf("v%0d_nfetch", idx), 256'(nf), 256'(v.nfetch));
    check($sformatf("v%0d_fetch_in_emit", idx), 256'(both), 256'(0));
    if (v.nfetch > 0) check($sformatf("v%0d_faddr0", idx), 256'(fa[0]), 256'(v.faddr0));
    if (v.nfetch > 1) check($sformatf("v%0d_faddr1", idx), 256'(fa[1]), 256'(v.faddr1));
    if (v.nuop > 0)
      check($sformatf("v%0d_first_uop_cycle", idx), 256'(first_k),
            256'((v.nfetch > 0) ? (3 + v.lat) : 2));
    if (v.stall > 0) check($sformatf("v%0d_stable", idx), 256'(stable_ok), 256'(1));
    check($sformatf("v%0d_error", idx), 256'(error_o), 256'(v.err));
    check($sformatf("v%0d_ready_after", idx), 256'(blk_ready_o), 256'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"}, 256'(blk_ready_o), 256'(1));
    check({tag, "_uop_valid"}, 256'(uop_valid_o), 256'(0));
    check({tag, "_fetch_req"}, 256'(fetch_req_o), 256'(0));
    check({tag, "_fetch_addr"}, 256'(fetch_addr_o), 256'(0));
    check({tag, "_error"}, 256'(error_o), 256'(0));
    check({tag, "_uop_fields"}, 256'(cur_uop()), 256'(0));
  endtask

  initial begin
    // Block table; iretire of the two-fetch block is 4 halfwords (2 + 1 + 1).
    vt[0] = mkv(64'h1000, 2, 1'b1, 2, 0, 64'h0, 3, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 64'h0, 64'h0, 1'b0);
    vt[1] = mkv(64'h2000, 4, 1'b0, 1, 3, 64'hdead, 1, 2, 2'b11, 2'b01, 1, 0, 3, 1, 2,
                64'h2000, 64'h2004, 1'b0);
    vt[2] = mkv(64'h2000, 4, 1'b0, 1, 3, 64'hdead, 1, 2, 2'b11, 2'b01, 1, 5, 3, 1, 2,
                64'h2000, 64'h2004, 1'b0);
    vt[3] = mkv(64'h2000, 4, 1'b0, 1, 3, 64'hdead, 1, 2, 2'b11, 2'b01, 3, 0, 3, 1, 2,
                64'h2000, 64'h2004, 1'b0);
    vt[4] = mkv(64'h9000, 0, 1'b1, 1, 1, 64'h1, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 64'h0, 64'h0, 1'b1);
    vt[5] = mkv(64'h5000, 3, 1'b1, 1, 1, 64'h1, 1, 1, 2'b11, 2'b00, 1, 0, 0, 0, 1,
                64'h5000, 64'h0, 1'b1);
    vt[6] = mkv(64'h6000, 1, 1'b1, 1, 1, 64'h1, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 64'h0, 64'h0, 1'b1);
    vt[7] = mkv(64'h4000, 1, 1'b0, 5, 2, 64'hbeef, 2, 0, 2'b00, 2'b00, 1, 0, 1, 4, 0,
                64'h0, 64'h0, 1'b1);
    vt[8] = mkv(64'hFFFF_FFFF_FFFF_FFFE, 3, 1'b1, 3, 7, 64'h55, 0, 1, 2'b00, 2'b00, 2, 0, 2, 5, 1,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b1);

    eu[0] = mku(64'h1000, 1'b0, 1'b1, 2, 0, 64'h0, 3);
    eu[1] = mku(64'h2000, 1'b0, 1'b0, 0, 0, 64'h0, 0);
    eu[2] = mku(64'h2004, 1'b1, 1'b0, 0, 0, 64'h0, 0);
    eu[3] = mku(64'h2006, 1'b1, 1'b1, 1, 3, 64'hdead, 1);
    eu[4] = mku(64'h4000, 1'b1, 1'b1, 5, 2, 64'hbeef, 2);
    eu[5] = mku(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0, 0, 64'h0, 0);
    eu[6] = mku(64'h0, 1'b0, 1'b1, 3, 7, 64'h55, 0);

    rst_ni = 1'b0; blk_valid_i = 1'b0; blk_iaddr_i = '0; blk_iretire_i = '0;
    blk_ilastsize_i = 1'b0; blk_itype_i = '0; blk_cause_i = '0; blk_tval_i = '0;
    blk_priv_i = '0; uop_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // Abort a block while it waits for a fetch response that never comes.
    rsp_q.delete();
    @(negedge clk);
    blk_valid_i = 1'b1; blk_iaddr_i = 64'h3000; blk_iretire_i = IRETIRE_LEN'(4);
    blk_ilastsize_i = 1'b0; blk_itype_i = '1; blk_cause_i = '1; blk_tval_i = '1; blk_priv_i = '1;
    @(negedge clk);
    blk_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", 256'(blk_ready_o), 256'(0));
    check("abort_err_before", 256'(error_o), 256'(1));
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("after_rst_ready", 256'(blk_ready_o), 256'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
